// File: rtl/mmio_pkg.sv
// Address map, status bit positions, IRQ code and UART state encoding shared by the MMIO block.
package mmio_pkg;
    localparam logic [63:0] ART_BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ART_STAT = 64'h0000_0000_8000_0008;
    localparam logic [63:0] KEY_BASE = 64'h0000_0000_8000_0010;

    localparam int ST_FULL = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_KEYV = 2;
    localparam int ST_OVF  = 3;
    localparam int ST_LOST = 4;

    localparam logic [3:0] IRQ_KEY = 4'd1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; pop data is combinational from the head entry.
// No internal guarding: caller pushes only when !full (or popping) and pops only when !empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr_q[AW-1:0]];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/mmio_uart_key.sv
// MMIO decode for a FIFO-fed 8N1 UART transmitter and a key latch with IRQ; reads return one cycle after acceptance.
// Bus accesses are edge-triggered and never stall; TX writes to a full FIFO are dropped and flagged sticky.
module mmio_uart_key
    import mmio_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] bus_address,
    input  logic [63:0] bus_write_data,
    input  logic        bus_write_enable,
    input  logic        bus_read_enable,
    output logic [63:0] bus_read_data,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_done,
    input  logic        key_strobe,
    input  logic [7:0]  key_data,
    output logic        uart_tx
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

    logic        we_hist_q, we_hist_d, re_hist_q, re_hist_d;
    logic        key_valid_q, key_valid_d;
    logic [7:0]  key_byte_q, key_byte_d;
    logic        tx_ovf_q, tx_ovf_d, key_lost_q, key_lost_d;
    logic [63:0] rd_data_q, rd_data_d;
    logic [63:0] status_word;
    logic        wr_acc, rd_acc, tx_wr, push, pop, fifo_full, fifo_empty;
    logic [7:0]  pop_dat;

    uart_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shreg_q;
    logic        uart_tx_q;

    logic unused_wdata;
    assign unused_wdata = ^bus_write_data[63:8];

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (push),
        .push_dat (bus_write_data[7:0]),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A pop frees a slot in the same cycle, so a write to a full FIFO still lands then.
    always_comb begin
        pop    = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && cnt_q == CNT_MAX));
        wr_acc = bus_write_enable && !we_hist_q;
        rd_acc = bus_read_enable && !re_hist_q;
        tx_wr  = wr_acc && (bus_address == ART_BASE);
        push   = tx_wr && (!fifo_full || pop);
        we_hist_d = bus_write_enable;
        re_hist_d = bus_read_enable;

        status_word          = '0;
        status_word[ST_FULL] = fifo_full;
        status_word[ST_BUSY] = (state_q != IDLE) || !fifo_empty;
        status_word[ST_KEYV] = key_valid_q;
        status_word[ST_OVF]  = tx_ovf_q;
        status_word[ST_LOST] = key_lost_q;

        rd_data_d = rd_data_q;
        if (rd_acc) begin
            case (bus_address)
                ART_STAT: rd_data_d = status_word;
                KEY_BASE: rd_data_d = {56'b0, key_byte_q};
                default:  rd_data_d = '0;
            endcase
        end

        // Sticky sets take priority over the read-clear in the same cycle.
        tx_ovf_d   = tx_ovf_q;
        key_lost_d = key_lost_q;
        if (rd_acc && bus_address == ART_STAT) begin
            tx_ovf_d   = 1'b0;
            key_lost_d = 1'b0;
        end
        if (tx_wr && !push) tx_ovf_d = 1'b1;

        key_valid_d = key_valid_q;
        key_byte_d  = key_byte_q;
        if (key_strobe) begin
            key_byte_d  = key_data;
            key_valid_d = 1'b1;
            if (key_valid_q) key_lost_d = 1'b1;
        end else if ((rd_acc && bus_address == KEY_BASE) || interrupt_done) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_hist_q   <= 1'b0;
            re_hist_q   <= 1'b0;
            key_valid_q <= 1'b0;
            key_byte_q  <= '0;
            tx_ovf_q    <= 1'b0;
            key_lost_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            we_hist_q   <= we_hist_d;
            re_hist_q   <= re_hist_d;
            key_valid_q <= key_valid_d;
            key_byte_q  <= key_byte_d;
            tx_ovf_q    <= tx_ovf_d;
            key_lost_q  <= key_lost_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shreg_q   <= pop_dat;
                        cnt_q     <= '0;
                        state_q   <= START;
                        uart_tx_q <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q     <= '0;
                        bit_q     <= '0;
                        state_q   <= DATA;
                        uart_tx_q <= shreg_q[0];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q   <= STOP;
                            uart_tx_q <= 1'b1;
                        end else begin
                            bit_q     <= bit_q + 3'd1;
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            uart_tx_q <= shreg_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (pop) begin
                            shreg_q   <= pop_dat;
                            state_q   <= START;
                            uart_tx_q <= 1'b0;
                        end else begin
                            state_q   <= IDLE;
                            uart_tx_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_read_data    = rd_data_q;
    assign interrupt_vector = key_valid_q ? IRQ_KEY : 4'd0;
    assign uart_tx          = uart_tx_q;
endmodule

// File: tb/tb_mmio_uart_key.sv
// Bench for mmio_uart_key: timeline-level reference model compared every cycle, plus literal directed checks.
module tb_mmio_uart_key;
    import mmio_pkg::*;

    localparam int B = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] bus_address = '0;
    logic [63:0] bus_write_data = '0;
    logic        bus_write_enable = 1'b0;
    logic        bus_read_enable = 1'b0;
    logic [63:0] bus_read_data;
    logic [3:0]  interrupt_vector;
    logic        interrupt_done = 1'b0;
    logic        key_strobe = 1'b0;
    logic [7:0]  key_data = '0;
    logic        uart_tx;

    mmio_uart_key #(.BAUD_DIV(B), .TX_DEPTH(D)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_write_enable (bus_write_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .interrupt_vector (interrupt_vector),
        .interrupt_done   (interrupt_done),
        .key_strobe       (key_strobe),
        .key_data         (key_data),
        .uart_tx          (uart_tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, line as "byte popped at cycle m_p, frame occupies m_p+1 .. m_p+10*B".
    logic [63:0] m_rd;
    logic        m_kv, m_ovf, m_lost, m_pwe, m_pre;
    logic [7:0]  m_kb, m_byte;
    logic [7:0]  m_q[$];
    int          m_p, m_next, m_pops, cyc;

    function automatic logic m_tx(input int c);
        int k;
        if (c >= m_p + 1 && c <= m_p + 10 * B) begin
            k = (c - m_p - 1) / B;
            if (k == 0) return 1'b0;
            if (k == 9) return 1'b1;
            return m_byte[k-1];
        end
        return 1'b1;
    endfunction

    initial cyc = 0;

    always @(posedge clk) begin
        logic wacc, racc, pop, full, busy, do_push;
        logic [63:0] status;
        if (!reset) begin
            m_rd = '0; m_kv = 0; m_kb = '0; m_ovf = 0; m_lost = 0;
            m_pwe = 0; m_pre = 0; m_q.delete();
            m_p = -100000; m_next = 0; m_byte = '0;
        end else begin
            wacc    = bus_write_enable && !m_pwe;
            racc    = bus_read_enable && !m_pre;
            pop     = (cyc >= m_next) && (m_q.size() > 0);
            full    = (m_q.size() == D);
            busy    = (m_q.size() > 0) || (cyc >= m_p + 1 && cyc <= m_p + 10 * B);
            status  = {59'b0, m_lost, m_ovf, m_kv, busy, full};
            do_push = 0;
            if (racc) begin
                if (bus_address == ART_STAT) begin
                    m_rd = status; m_ovf = 0; m_lost = 0;
                end else if (bus_address == KEY_BASE) m_rd = {56'b0, m_kb};
                else m_rd = '0;
            end
            if (wacc && bus_address == ART_BASE) begin
                if (!full || pop) do_push = 1;
                else m_ovf = 1;
            end
            if (key_strobe) begin
                if (m_kv) m_lost = 1;
                m_kb = key_data; m_kv = 1;
            end else if ((racc && bus_address == KEY_BASE) || interrupt_done) m_kv = 0;
            if (pop) begin
                m_byte = m_q.pop_front(); m_p = cyc; m_next = cyc + 10 * B; m_pops++;
            end
            if (do_push) m_q.push_back(bus_write_data[7:0]);
            m_pwe = bus_write_enable;
            m_pre = bus_read_enable;
        end
        cyc++;
        #1;
        check("rd_data", bus_read_data, m_rd);
        check("irq", 64'(interrupt_vector), m_kv ? 64'(IRQ_KEY) : 64'd0);
        check("uart_tx", 64'(uart_tx), 64'(m_tx(cyc)));
    end

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wr(input logic [63:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_address = a;
        bus_write_data = {$urandom, $urandom_range(0, 16777215), d};
        bus_write_enable = 1;
        @(negedge clk);
        bus_write_enable = 0;
    endtask

    task automatic rd(input logic [63:0] a, output logic [63:0] d);
        @(negedge clk);
        bus_address = a;
        bus_read_enable = 1;
        @(posedge clk);
        #1 d = bus_read_data;
        @(negedge clk);
        bus_read_enable = 0;
    endtask

    task automatic strobe(input logic [7:0] kd, input logic done);
        @(negedge clk);
        key_strobe = 1; key_data = kd; interrupt_done = done;
        @(negedge clk);
        key_strobe = 0; interrupt_done = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        logic [9:0]  pat;
        logic [63:0] addrs [5];
        int          pops0;
        m_pops = 0;
        addrs[0] = ART_BASE; addrs[1] = ART_STAT; addrs[2] = KEY_BASE;
        addrs[3] = 64'h8000_0020; addrs[4] = 64'h1_8000_0000;

        idle(3);
        #2;
        check("reset_rd", bus_read_data, 64'd0);
        check("reset_irq", 64'(interrupt_vector), 64'd0);
        check("reset_tx", 64'(uart_tx), 64'd1);
        @(negedge clk) reset = 1;
        idle(3);

        // 0x41 frame, literal bit pattern LSB first, start bit two cycles after acceptance.
        pat = {1'b1, 8'h41, 1'b0};
        @(negedge clk);
        bus_address = ART_BASE; bus_write_data = 64'h41; bus_write_enable = 1;
        @(posedge clk);
        @(negedge clk) bus_write_enable = 0;
        for (int i = 0; i < 10 * B; i++) begin
            @(posedge clk);
            #1 check($sformatf("frame41_bit%0d", i / B), 64'(uart_tx), 64'(pat[i/B]));
        end
        idle(5);

        // Enable held high: one access only.
        pops0 = m_pops;
        @(negedge clk);
        bus_address = ART_BASE; bus_write_data = 64'hC3; bus_write_enable = 1;
        idle(20);
        bus_write_enable = 0;
        idle(50);
        check("held_we_frames", 64'(m_pops - pops0), 64'd1);

        // Nine writes fit (one in flight + eight queued); the tenth overflows.
        pops0 = m_pops;
        for (int i = 0; i < 9; i++) wr(ART_BASE, 8'h30 + 8'(i));
        wr(ART_BASE, 8'hEE);
        rd(ART_STAT, d);
        check("stat_ovf_set", (d >> 3) & 64'd1, 64'd1);
        check("stat_full", d & 64'd1, 64'd1);
        rd(ART_STAT, d);
        check("stat_ovf_clr", (d >> 3) & 64'd1, 64'd0);
        idle(9 * 10 * B + 20);
        check("burst_frames", 64'(m_pops - pops0), 64'd9);

        strobe(8'h5A, 0);
        check("key_irq", 64'(interrupt_vector), 64'd1);
        rd(KEY_BASE, d);
        check("key_byte", d, 64'h5A);
        check("key_irq_clr", 64'(interrupt_vector), 64'd0);

        strobe(8'h11, 0);
        strobe(8'h22, 0);
        rd(KEY_BASE, d);
        check("key_overwrite", d, 64'h22);
        rd(ART_STAT, d);
        check("stat_key_lost", (d >> 4) & 64'd1, 64'd1);
        strobe(8'h33, 0);
        strobe(8'h44, 1);
        check("strobe_beats_done", 64'(interrupt_vector), 64'd1);
        strobe(8'h00, 0);
        @(negedge clk) interrupt_done = 1;
        @(negedge clk) interrupt_done = 0;
        check("done_clears_irq", 64'(interrupt_vector), 64'd0);

        rd(64'h8000_0020, d);
        check("unmapped_read", d, 64'd0);

        // Randomised traffic, then drain.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus_address      = addrs[$urandom_range(0, 4)];
            bus_write_data   = {$urandom, $urandom};
            bus_write_enable = ($urandom_range(0, 3) == 0);
            bus_read_enable  = ($urandom_range(0, 2) == 0);
            key_strobe       = ($urandom_range(0, 7) == 0);
            key_data         = 8'($urandom);
            interrupt_done   = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        bus_write_enable = 0; bus_read_enable = 0; key_strobe = 0; interrupt_done = 0;
        idle(10 * B * (D + 2));

        // Asynchronous reset in the middle of a frame.
        strobe(8'h77, 0);
        wr(ART_BASE, 8'h00);
        idle(6);
        #2;
        check("tx_low_before_reset", 64'(uart_tx), 64'd0);
        check("irq_before_reset", 64'(interrupt_vector), 64'd1);
        reset = 0;
        #1;
        check("async_reset_tx", 64'(uart_tx), 64'd1);
        check("async_reset_irq", 64'(interrupt_vector), 64'd0);
        idle(3);
        @(negedge clk) reset = 1;
        idle(10);
        rd(ART_STAT, d);
        check("post_reset_stat", d, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_uart_key.md
# mmio_uart_key

Memory-mapped peripheral block directly downstream of the riscv64 core's bus master port. Decodes `bus_address` and owns two devices: a UART transmitter behind an 8-entry FIFO at ART_BASE, and a keyboard byte latch at KEY_BASE. It also drives the core's `interrupt_vector`, raising vector 1 on a received key byte and retiring it on `interrupt_done` or on a key read.

## Interface
Parameters:
- `BAUD_DIV`, 434: clocks per UART bit (50 MHz / 115200); must be ≥ 2.
- `TX_DEPTH`, 8: TX FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bus_address`  in  64  byte address from the core.
- `bus_write_data`  in  64  write data; only [7:0] is used.
- `bus_write_enable`  in  1  write request level.
- `bus_read_enable`  in  1  read request level.
- `bus_read_data`  out  64  registered read data.
- `interrupt_vector`  out  4  4'd1 = key interrupt pending, 4'd0 = none.
- `interrupt_done`  in  1  one-cycle pulse from the core: ISR finished.
- `key_strobe`  in  1  one-cycle pulse: `key_data` valid.
- `key_data`  in  8  received key byte.
- `uart_tx`  out  1  serial output, 8N1, idle high.

## Operation
- Address map (full 64-bit compare): ART_BASE 0x8000_0000 write = TX byte; ART_STAT 0x8000_0008 read = status; KEY_BASE 0x8000_0010 read = key byte. Other addresses: writes ignored, reads return 0.
- Status word: bit0 fifo_full, bit1 tx_busy (FSM not IDLE or FIFO non-empty), bit2 key_valid, bit3 tx_overflow (sticky), bit4 key_lost (sticky); other bits 0. Reading ART_STAT clears both sticky bits.
- Request acceptance is edge-based: a write (read) is accepted only in the cycle where `bus_write_enable` (`bus_read_enable`) is 1 and was 0 in the previous cycle. Holding an enable high yields exactly one access. Write and read rising simultaneously: both accepted.
- TX write: push `bus_write_data[7:0]`. Accepted if FIFO not full, or if the UART pops in the same cycle; otherwise dropped and tx_overflow set.
- Key latch: `key_strobe` loads key_byte, sets key_valid. If key_valid already 1, byte is overwritten and key_lost set.
- KEY_BASE read returns {56'b0, key_byte} and clears key_valid. `key_strobe` in the same cycle wins: new byte latched, key_valid stays 1.
- Interrupt: `interrupt_vector` = 4'd1 iff key_valid, else 4'd0. `interrupt_done` clears key_valid (byte retained); `key_strobe` in the same cycle wins.
- UART FSM: IDLE → START (FIFO non-empty; pop byte into shift reg) → DATA (8 bits, LSB first) → STOP → IDLE. Each state bit lasts exactly `BAUD_DIV` clocks. From STOP with FIFO non-empty, go directly to START.

## Timing
- Reset values: `bus_read_data` 0, `interrupt_vector` 0, `uart_tx` 1. FIFO empty, FSM IDLE, key_valid 0, sticky bits 0, edge-detect history 0.
- Read latency 1: data valid on the edge after acceptance and held until the next accepted read.
- Key→interrupt: `interrupt_vector` is 1 in the cycle after the `key_strobe` edge. Clear takes effect on the edge after `interrupt_done` or the read acceptance.
- Write→serial: start bit appears on `uart_tx` 2 cycles after write acceptance when idle (push, then pop/START). A frame lasts 10·BAUD_DIV clocks.
- Reset mid-frame: `uart_tx` returns to 1 immediately (async); FIFO contents are lost.
- FIFO pointers are log2(TX_DEPTH)+1 bits with a wrap bit. Full = MSBs differ and the rest are equal. Wrap-around is exercised after TX_DEPTH pushes.

## Structure
- Package `mmio_pkg`: ART_BASE, ART_STAT, KEY_BASE constants, status bit indices, IRQ_KEY = 4'd1, UART state enum {IDLE, START, DATA, STOP}.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty). Everything else lives in the top level.

## Test plan
- Reset with BAUD_DIV=4, then write 0x41 to 0x8000_0000 → `uart_tx` shows 0, then 1,0,0,0,0,0,1,0, then 1, each for 4 clocks; start bit 2 cycles after acceptance.
- Hold `bus_write_enable` high for 20 cycles at ART_BASE → exactly one frame transmitted.
- 9 back-to-back writes while the first frame is sending, TX_DEPTH=8 → 9 frames total, no overflow. A 10th write to a full FIFO → dropped; ART_STAT read returns bit3=1, and a second read returns bit3=0.
- `key_strobe` with 0x5A → `interrupt_vector`=1 next cycle; KEY_BASE read → `bus_read_data`=0x5A one cycle later and `interrupt_vector`=0.
- Two strobes (0x11, 0x22) without a read → KEY_BASE returns 0x22, status bit4=1. `key_strobe` coincident with `interrupt_done` → vector stays 1.
- Read of 0x8000_0020 → 0. Assert `reset` low mid-frame → `uart_tx`=1 and `interrupt_vector`=0 without waiting for a clock edge.
